// File: rtl/laundry_pkg.sv
// Shared types and constants for the laundry request scheduler slice.
// Floor indices are 0..3; floors travel between blocks as one-hot vectors.
package laundry_pkg;

    localparam int NUM_FLOORS = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        RETIRE    = 3'd3,
        GAP       = 3'd4
    } state_t;

    localparam logic [NUM_FLOORS-1:0] FLOOR0 = 4'b0001;
    localparam logic [NUM_FLOORS-1:0] FLOOR1 = 4'b0010;
    localparam logic [NUM_FLOORS-1:0] FLOOR2 = 4'b0100;
    localparam logic [NUM_FLOORS-1:0] FLOOR3 = 4'b1000;

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_FLOORS-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick: the first set pending bit at or after
// rr_ptr (ascending, wrapping 3->0) wins and is returned one-hot.
module rr_arbiter4
    import laundry_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [1:0]            rr_ptr,
    output logic [NUM_FLOORS-1:0] grant,
    output logic                  valid
);

    logic [1:0] idx;

    // Scan from the farthest candidate back to rr_ptr so the nearest one lands last.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            idx = rr_ptr + 2'(i);
            if (pending[idx]) grant = FLOOR0 << idx;
        end
    end

    assign valid = |pending;

endmodule

// File: rtl/laundry_request_scheduler.sv
// Captures per-floor laundry calls, issues one floor at a time round-robin to
// the laundry controller, and retires each job on wash_done or watchdog expiry.
module laundry_request_scheduler
    import laundry_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200,
    parameter int TMR_W          = 8,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic                  wash_done,
    output logic                  start,
    output logic [NUM_FLOORS-1:0] req_laundry,
    output logic [NUM_FLOORS-1:0] send,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy,
    output logic                  timeout_err,
    output state_t                state_dbg
);

    // Handshake: start is a one-cycle launch with req_laundry/send valid; the
    // floor is held until wash_done (only honoured in WAIT_DONE) or the watchdog.
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST     = TMR_W'(GAP_CYCLES - 1);

    state_t                state, state_next;
    logic [NUM_FLOORS-1:0] pending_q, grant, grant_clr;
    logic [NUM_FLOORS-1:0] cur_floor, cur_floor_next;
    logic [1:0]            rr_ptr, rr_ptr_next;
    logic [TMR_W-1:0]      timer, timer_next;
    logic                  grant_valid;

    rr_arbiter4 u_arb (
        .pending (pending_q),
        .rr_ptr  (rr_ptr),
        .grant   (grant),
        .valid   (grant_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pending_q <= '0;
            cur_floor <= '0;
            rr_ptr    <= '0;
            timer     <= '0;
        end else begin
            state     <= state_next;
            pending_q <= (pending_q & ~grant_clr) | call_btn;
            cur_floor <= cur_floor_next;
            rr_ptr    <= rr_ptr_next;
            timer     <= timer_next;
        end
    end

    // The winner's pending bit is dropped on the edge into ISSUE, so it never shows while served.
    always_comb begin
        state_next     = state;
        cur_floor_next = cur_floor;
        rr_ptr_next    = rr_ptr;
        timer_next     = timer;
        grant_clr      = '0;
        start          = 1'b0;
        req_laundry    = '0;
        timeout_err    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next     = ISSUE;
                    cur_floor_next = grant;
                    grant_clr      = grant;
                end
            end
            ISSUE: begin
                start       = 1'b1;
                req_laundry = cur_floor;
                timer_next  = '0;
                state_next  = WAIT_DONE;
            end
            WAIT_DONE: begin
                req_laundry = cur_floor;
                timer_next  = timer + 1'b1;
                if (wash_done) begin
                    state_next = RETIRE;
                end else if (timer == TIMEOUT_LAST) begin
                    timeout_err = 1'b1;
                    state_next  = RETIRE;
                end
            end
            RETIRE: begin
                rr_ptr_next    = onehot_to_idx(cur_floor) + 2'd1;
                cur_floor_next = '0;
                timer_next     = '0;
                state_next     = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (timer == GAP_LAST) begin
                    timer_next = '0;
                    state_next = IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign send      = req_laundry;
    assign pending   = pending_q;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: doc/laundry_request_scheduler.md
Name: laundry_request_scheduler

Overview:
Upstream stage of the laundry controller FSM. Captures per-floor laundry call pulses into a pending register and picks one floor at a time, round-robin. It presents that floor as one-hot req_laundry/send with a one-cycle start pulse, then holds until the controller reports wash_done. A watchdog timer retires a job that never completes, so a stuck controller cannot starve the other floors.

Parameters:
TIMEOUT_CYCLES, 200, cycles in WAIT_DONE before forced retire; must exceed worst-case controller cycle time (>60 counts).
TMR_W, 8, width of watchdog counter; must hold TIMEOUT_CYCLES.
GAP_CYCLES, 2, minimum idle cycles between retire and next start (lets controller return to idle).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
call_btn  in  4  per-floor request pulses, synchronous to clk; bit i = floor i.
wash_done  in  1  from controller; completion of current job, sampled only in WAIT_DONE.
start  out  1  one-cycle pulse to controller launching a job.
req_laundry  out  4  one-hot pickup floor of current job; 0 when no job.
send  out  4  one-hot return floor; equals req_laundry (laundry returns to origin floor).
pending  out  4  outstanding requests not yet in service.
busy  out  1  high from ISSUE through RETIRE/GAP.
timeout_err  out  1  one-cycle pulse when the watchdog retires a job.

Behaviour:
- Reset (reset=0, async): state=IDLE; pending=0; rr_ptr=0; timer=0; all outputs 0.
- Pending update every cycle: pending_next = (pending & ~grant_clr) | call_btn. A set on the same bit in the same cycle wins over the clear, so a repeat press during its own service is re-queued.
- The floor in service has its pending bit cleared in ISSUE (grant_clr); it is not shown as pending while served.
- Arbitration: round-robin search starting at rr_ptr, ascending, wrapping 3->0. First set pending bit wins. After retire, rr_ptr = served floor + 1 mod 4.
- FSM:
  - IDLE: if pending != 0 -> ISSUE, latch winner into cur_floor (one-hot); else stay.
  - ISSUE (1 cycle): start=1; req_laundry=send=cur_floor; clear the pending bit; timer=0 -> WAIT_DONE.
  - WAIT_DONE: req_laundry/send held; timer increments. If wash_done=1 -> RETIRE. Else if timer==TIMEOUT_CYCLES-1 -> RETIRE with timeout_err pulse in that cycle. wash_done takes priority if both occur in the same cycle (no error).
  - RETIRE (1 cycle): req_laundry=send=0; advance rr_ptr; timer=0 -> GAP.
  - GAP: count GAP_CYCLES cycles, then -> IDLE. With GAP_CYCLES=0, go straight to IDLE.
- Latency: call_btn in cycle N with IDLE and no other pending: pending visible N+1, ISSUE/start at N+2.
- wash_done outside WAIT_DONE is ignored. start is never asserted outside ISSUE.
- Reset mid-job: immediate return to reset values; the job in flight and all pending requests are dropped.
- busy=1 in ISSUE, WAIT_DONE, RETIRE, GAP.

Decomposition:
- Shared package laundry_pkg: state enum (IDLE, ISSUE, WAIT_DONE, RETIRE, GAP), NUM_FLOORS=4, floor one-hot constants.
- One sub-module, rr_arbiter4: combinational 4-bit round-robin priority pick (pending, rr_ptr -> one-hot grant, valid). The FSM, timer and pending register stay in the top.

Test Plan:
- Single request: pulse call_btn=4'b0100 at cycle 5 -> pending=0100 at 6, start=1 and req_laundry=send=0100 at 7, pending=0; wash_done at 20 -> req_laundry=0 at 21, busy=0 after GAP.
- Round-robin: pulse call_btn=4'b1011 at once, complete each job with wash_done -> service order floor0, floor1, floor3; a later call on floor 0 is served before floor 1 again only after floor 3.
- Wrap: rr_ptr=3 after serving floor 2, pending=1001 -> floor3 served, then floor0.
- Timeout: issue floor1, never assert wash_done -> timeout_err pulse exactly TIMEOUT_CYCLES cycles after start (200), job retired, next pending floor issued after GAP.
- Simultaneous events: during WAIT_DONE on floor2, pulse call_btn[2] in the same cycle as wash_done -> no timeout_err, pending[2]=1 after retire, floor2 reissued next.
- Async reset mid-job: assert reset=0 in WAIT_DONE between clock edges -> outputs 0 immediately (before the next edge), pending=0; release -> stays IDLE with no start.
